// File: rtl/tt_sweep_ctrl.sv
// Truth-table sweep sequencer: walks a combinational netlist through every input
// combination, captures its output table and scores it against an expected table.
module tt_sweep_ctrl #(
   parameter int  N_IN          = 4,
   parameter int  SETTLE_CYCLES = 2,
   localparam int W             = 2**N_IN,
   localparam int CW            = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            abort,
   input  logic [W-1:0]    exp_tt,
   output logic [N_IN-1:0] dut_in,
   input  logic            dut_out,
   output logic            busy,
   output logic            done,
   output logic            result_valid,
   output logic            pass,
   output logic [W-1:0]    tt_captured,
   output logic [N_IN:0]   mismatch_cnt,
   output logic [N_IN-1:0] first_fail
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SETTLE = 2'd1;
   localparam logic [1:0] S_SAMPLE = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   localparam logic [CW-1:0]   SETTLE_INIT = CW'(SETTLE_CYCLES);
   localparam logic [CW-1:0]   CNT_ONE     = CW'(1);
   localparam logic [N_IN-1:0] LAST_COMB   = '1;

   logic [1:0]      state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [N_IN-1:0] comb_q, comb_d;
   logic [W-1:0]    exp_q, exp_d;
   logic [W-1:0]    tt_q, tt_d;
   logic [N_IN:0]   mis_q, mis_d;
   logic [N_IN-1:0] first_q, first_d;
   logic            fail_seen_q, fail_seen_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            valid_q, valid_d;
   logic            exp_bit;

   // Combination c lives at table bit W-1-c, which is simply the bitwise complement of c.
   assign exp_bit = exp_q[~comb_q];

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      comb_d      = comb_q;
      exp_d       = exp_q;
      tt_d        = tt_q;
      mis_d       = mis_q;
      first_d     = first_q;
      fail_seen_d = fail_seen_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      valid_d     = valid_q;

      case (state_q)
         S_IDLE: begin
            if (start && !abort) begin
               exp_d       = exp_tt;
               tt_d        = '0;
               mis_d       = '0;
               first_d     = '0;
               fail_seen_d = 1'b0;
               valid_d     = 1'b0;
               comb_d      = '0;
               busy_d      = 1'b1;
               cnt_d       = SETTLE_INIT;
               state_d     = S_SETTLE;
            end
         end

         S_SETTLE: begin
            if (abort) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
               comb_d  = '0;
               valid_d = 1'b0;
            end else if (cnt_q <= CNT_ONE) begin
               state_d = S_SAMPLE;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end

         S_SAMPLE: begin
            if (abort) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
               comb_d  = '0;
               valid_d = 1'b0;
            end else begin
               tt_d = {tt_q[W-2:0], dut_out};
               if (dut_out != exp_bit) begin
                  mis_d = mis_q + 1'b1;
                  if (!fail_seen_q) begin
                     first_d     = comb_q;
                     fail_seen_d = 1'b1;
                  end
               end
               // The last combination stays on dut_in after the sweep finishes.
               if (comb_q == LAST_COMB) begin
                  state_d = S_DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  valid_d = 1'b1;
               end else begin
                  comb_d  = comb_q + 1'b1;
                  cnt_d   = SETTLE_INIT;
                  state_d = S_SETTLE;
               end
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         comb_q      <= '0;
         exp_q       <= '0;
         tt_q        <= '0;
         mis_q       <= '0;
         first_q     <= '0;
         fail_seen_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         valid_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         comb_q      <= comb_d;
         exp_q       <= exp_d;
         tt_q        <= tt_d;
         mis_q       <= mis_d;
         first_q     <= first_d;
         fail_seen_q <= fail_seen_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         valid_q     <= valid_d;
      end
   end

   assign dut_in       = comb_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign result_valid = valid_q;
   assign pass         = valid_q && (mis_q == '0);
   assign tt_captured  = tt_q;
   assign mismatch_cnt = mis_q;
   assign first_fail   = first_q;

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Scoreboard bench for tt_sweep_ctrl: a netlist model answers dut_in, expected sweep
// results are queued at launch and compared when done pulses.
module tb_tt_sweep_ctrl;

   typedef struct packed {
      logic [15:0] tt;
      logic [4:0]  mis;
      logic [3:0]  ff;
      logic        pass;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        start;
   logic        abort;
   logic [15:0] exp_tt;
   logic [3:0]  dut_in;
   logic        dut_out;
   logic        busy;
   logic        done;
   logic        result_valid;
   logic        pass;
   logic [15:0] tt_captured;
   logic [4:0]  mismatch_cnt;
   logic [3:0]  first_fail;

   int          vectors;
   int          miscompares;
   exp_t        sb[$];

   // Netlist model: 0 = combinational table, 1 = output tied low, 2 = table with 2-cycle delay
   int          mode;
   logic [15:0] model_tt;
   logic        dly1, dly2;

   tt_sweep_ctrl #(.N_IN(4), .SETTLE_CYCLES(2)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .abort        (abort),
      .exp_tt       (exp_tt),
      .dut_in       (dut_in),
      .dut_out      (dut_out),
      .busy         (busy),
      .done         (done),
      .result_valid (result_valid),
      .pass         (pass),
      .tt_captured  (tt_captured),
      .mismatch_cnt (mismatch_cnt),
      .first_fail   (first_fail)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) begin
      dly1 <= model_tt[~dut_in];
      dly2 <= dly1;
   end

   always_comb begin
      dut_out = 1'b0;
      case (mode)
         0:       dut_out = model_tt[~dut_in];
         1:       dut_out = 1'b0;
         default: dut_out = dly2;
      endcase
   end

   // Expected sweep outcome: combination c answers net[15-c], scored against ev[15-c].
   function automatic exp_t predict(input logic [15:0] net, input logic [15:0] ev);
      exp_t r;
      logic seen;
      logic b;
      r    = '0;
      seen = 1'b0;
      for (int c = 0; c < 16; c++) begin
         b    = net[15-c];
         r.tt = {r.tt[14:0], b};
         if (b != ev[15-c]) begin
            r.mis = r.mis + 5'd1;
            if (!seen) begin
               r.ff = 4'(c);
               seen = 1'b1;
            end
         end
      end
      r.pass = (r.mis == 5'd0);
      return r;
   endfunction

   // Pulses start for one cycle; on return the bench sits in cycle 1 after the accepting edge.
   task automatic launch(input logic [15:0] ev, input bit expectResult);
      @(negedge clk);
      start  = 1'b1;
      exp_tt = ev;
      if (expectResult) sb.push_back(predict((mode == 1) ? 16'h0000 : model_tt, ev));
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(output int cyc, output bit timeout);
      cyc     = 1;
      timeout = 1'b0;
      while (done !== 1'b1) begin
         if (cyc >= 400) begin
            timeout = 1'b1;
            break;
         end
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      vectors++;
      if ({busy, done, result_valid, pass, tt_captured, mismatch_cnt, first_fail, dut_in} !== '0) begin
         miscompares++;
         $display("[TB] FAIL reset_held: busy=%b done=%b valid=%b pass=%b tt=%h mis=%0d ff=%h din=%h, want all 0",
                  busy, done, result_valid, pass, tt_captured, mismatch_cnt, first_fail, dut_in);
      end
      rst = 1'b0;
      @(negedge clk);
      vectors++;
      if ({busy, done, result_valid, pass, tt_captured, mismatch_cnt, first_fail, dut_in} !== '0) begin
         miscompares++;
         $display("[TB] FAIL reset_released: busy=%b done=%b valid=%b tt=%h mis=%0d, want all 0",
                  busy, done, result_valid, tt_captured, mismatch_cnt);
      end
   endtask

   task automatic test_match();
      int cyc;
      bit to;
      exp_t e;
      mode     = 0;
      model_tt = 16'h7176;
      launch(16'h7176, 1'b1);
      wait_done(cyc, to);
      e = sb.pop_front();
      vectors++;
      if (to || cyc != 49) begin
         miscompares++;
         $display("[TB] FAIL match_latency: done at cycle %0d timeout=%0b, want 49", cyc, to);
      end
      vectors++;
      if ({tt_captured, mismatch_cnt, first_fail, pass, result_valid, busy} !== {e.tt, e.mis, e.ff, e.pass, 1'b1, 1'b0}) begin
         miscompares++;
         $display("[TB] FAIL match_result: tt=%h mis=%0d ff=%h pass=%b valid=%b busy=%b, want tt=%h mis=%0d ff=%h pass=%b valid=1 busy=0",
                  tt_captured, mismatch_cnt, first_fail, pass, result_valid, busy, e.tt, e.mis, e.ff, e.pass);
      end
      @(negedge clk);
      vectors++;
      if ({done, result_valid, pass, dut_in, tt_captured} !== {1'b0, 1'b1, e.pass, 4'hF, e.tt}) begin
         miscompares++;
         $display("[TB] FAIL match_hold: done=%b valid=%b pass=%b din=%h tt=%h, want done=0 valid=1 pass=%b din=f tt=%h",
                  done, result_valid, pass, dut_in, tt_captured, e.pass, e.tt);
      end
   endtask

   task automatic test_single_mismatch();
      int cyc;
      bit to;
      exp_t e;
      mode     = 0;
      model_tt = 16'h7176;
      launch(16'h7177, 1'b1);
      wait_done(cyc, to);
      e = sb.pop_front();
      vectors++;
      if (to || {tt_captured, mismatch_cnt, first_fail, pass} !== {e.tt, e.mis, e.ff, e.pass}) begin
         miscompares++;
         $display("[TB] FAIL single_mismatch: timeout=%0b tt=%h mis=%0d ff=%h pass=%b, want tt=%h mis=%0d ff=%h pass=%b",
                  to, tt_captured, mismatch_cnt, first_fail, pass, e.tt, e.mis, e.ff, e.pass);
      end
   endtask

   task automatic test_stuck_zero();
      int cyc;
      bit to;
      exp_t e;
      mode = 1;
      launch(16'h7176, 1'b1);
      wait_done(cyc, to);
      e = sb.pop_front();
      vectors++;
      if (to || {tt_captured, mismatch_cnt, first_fail, pass} !== {e.tt, e.mis, e.ff, e.pass}) begin
         miscompares++;
         $display("[TB] FAIL stuck_zero: timeout=%0b tt=%h mis=%0d ff=%h pass=%b, want tt=%h mis=%0d ff=%h pass=%b",
                  to, tt_captured, mismatch_cnt, first_fail, pass, e.tt, e.mis, e.ff, e.pass);
      end
      // abort landing on the done cycle must not disturb the finished results
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      vectors++;
      if ({result_valid, mismatch_cnt, first_fail, busy, dut_in} !== {1'b1, e.mis, e.ff, 1'b0, 4'hF}) begin
         miscompares++;
         $display("[TB] FAIL abort_in_done: valid=%b mis=%0d ff=%h busy=%b din=%h, want valid=1 mis=%0d ff=%h busy=0 din=f",
                  result_valid, mismatch_cnt, first_fail, busy, dut_in, e.mis, e.ff);
      end
   endtask

   task automatic test_abort();
      int cyc;
      bit to;
      int dones;
      exp_t e;
      mode     = 0;
      model_tt = 16'h7176;
      launch(16'h7176, 1'b0);
      repeat (19) @(negedge clk);
      vectors++;
      if (busy !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL abort_pre_busy: busy=%b, want 1", busy);
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      vectors++;
      if ({busy, result_valid, dut_in, done} !== 7'd0) begin
         miscompares++;
         $display("[TB] FAIL abort_state: busy=%b valid=%b din=%h done=%b, want all 0",
                  busy, result_valid, dut_in, done);
      end
      dones = 0;
      repeat (60) begin
         @(negedge clk);
         if (done === 1'b1) dones++;
      end
      vectors++;
      if (dones != 0) begin
         miscompares++;
         $display("[TB] FAIL abort_no_done: %0d done pulses, want 0", dones);
      end
      // start and abort together in IDLE: the start is dropped
      @(negedge clk);
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL abort_beats_start: busy=%b, want 0", busy);
      end
      launch(16'h7176, 1'b1);
      wait_done(cyc, to);
      e = sb.pop_front();
      vectors++;
      if (to || cyc != 49 || {tt_captured, mismatch_cnt, pass} !== {e.tt, e.mis, e.pass}) begin
         miscompares++;
         $display("[TB] FAIL abort_rerun: cycle=%0d timeout=%0b tt=%h mis=%0d pass=%b, want cycle=49 tt=%h mis=%0d pass=%b",
                  cyc, to, tt_captured, mismatch_cnt, pass, e.tt, e.mis, e.pass);
      end
   endtask

   task automatic test_async_reset();
      int dones;
      int dcyc;
      exp_t e;
      mode     = 0;
      model_tt = 16'h7176;
      launch(16'h7177, 1'b0);
      repeat (3) @(negedge clk);
      vectors++;
      if (busy !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL areset_pre_busy: busy=%b, want 1", busy);
      end
      #2 rst = 1'b1;
      #1;
      vectors++;
      if ({busy, done, result_valid, pass, tt_captured, mismatch_cnt, first_fail, dut_in} !== '0) begin
         miscompares++;
         $display("[TB] FAIL areset_immediate: busy=%b valid=%b tt=%h mis=%0d ff=%h din=%h, want all 0",
                  busy, result_valid, tt_captured, mismatch_cnt, first_fail, dut_in);
      end
      @(negedge clk);
      rst = 1'b0;
      // start held high well into the sweep must arm exactly one sweep
      @(negedge clk);
      start  = 1'b1;
      exp_tt = 16'h7176;
      sb.push_back(predict(model_tt, 16'h7176));
      dones = 0;
      dcyc  = 0;
      for (int k = 1; k <= 150; k++) begin
         @(negedge clk);
         if (k == 30) start = 1'b0;
         if (done === 1'b1) begin
            dones++;
            dcyc = k;
            if (sb.size() > 0) begin
               e = sb.pop_front();
               vectors++;
               if ({tt_captured, mismatch_cnt, pass} !== {e.tt, e.mis, e.pass}) begin
                  miscompares++;
                  $display("[TB] FAIL held_start_result: tt=%h mis=%0d pass=%b, want tt=%h mis=%0d pass=%b",
                           tt_captured, mismatch_cnt, pass, e.tt, e.mis, e.pass);
               end
            end
         end
      end
      vectors++;
      if (dones != 1 || dcyc != 49) begin
         miscompares++;
         $display("[TB] FAIL held_start_once: %0d done pulses, last at cycle %0d, want 1 at 49", dones, dcyc);
      end
   endtask

   task automatic test_dut_in_sequence();
      exp_t e;
      int bad;
      mode     = 2;
      model_tt = 16'h7176;
      launch(16'h7176, 1'b1);
      bad = 0;
      for (int k = 1; k <= 48; k++) begin
         vectors++;
         if (dut_in !== 4'((k - 1) / 3) || done !== 1'b0) begin
            miscompares++;
            bad++;
            if (bad < 4)
               $display("[TB] FAIL dut_in_step: cycle %0d din=%h done=%b, want din=%h done=0",
                        k, dut_in, done, 4'((k - 1) / 3));
         end
         @(negedge clk);
      end
      e = sb.pop_front();
      vectors++;
      if ({done, tt_captured, mismatch_cnt, pass} !== {1'b1, e.tt, e.mis, e.pass}) begin
         miscompares++;
         $display("[TB] FAIL delayed_netlist: done=%b tt=%h mis=%0d pass=%b, want done=1 tt=%h mis=%0d pass=%b",
                  done, tt_captured, mismatch_cnt, pass, e.tt, e.mis, e.pass);
      end
   endtask

   task automatic test_back_to_back();
      int cyc;
      bit to;
      exp_t e;
      mode     = 0;
      model_tt = 16'hA5C3;
      // every combination differs: count reaches W without wrapping
      launch(16'h5A3C, 1'b1);
      repeat (9) @(negedge clk);
      exp_tt = 16'hA5C3;
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      wait_done(cyc, to);
      e = sb.pop_front();
      vectors++;
      if (to || cyc != 39 || {tt_captured, mismatch_cnt, first_fail, pass} !== {e.tt, e.mis, e.ff, e.pass}) begin
         miscompares++;
         $display("[TB] FAIL all_differ: cycle=%0d timeout=%0b tt=%h mis=%0d ff=%h pass=%b, want cycle=39 tt=%h mis=%0d ff=%h pass=%b",
                  cyc, to, tt_captured, mismatch_cnt, first_fail, pass, e.tt, e.mis, e.ff, e.pass);
      end
      model_tt = 16'h8001;
      launch(16'h8001, 1'b1);
      wait_done(cyc, to);
      e = sb.pop_front();
      vectors++;
      if (to || cyc != 49 || {tt_captured, mismatch_cnt, first_fail, pass} !== {e.tt, e.mis, e.ff, e.pass}) begin
         miscompares++;
         $display("[TB] FAIL back_to_back: cycle=%0d timeout=%0b tt=%h mis=%0d ff=%h pass=%b, want cycle=49 tt=%h mis=%0d ff=%h pass=%b",
                  cyc, to, tt_captured, mismatch_cnt, first_fail, pass, e.tt, e.mis, e.ff, e.pass);
      end
      vectors++;
      if (sb.size() != 0) begin
         miscompares++;
         $display("[TB] FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst         = 1'b1;
      start       = 1'b0;
      abort       = 1'b0;
      exp_tt      = '0;
      mode        = 0;
      model_tt    = '0;
      test_reset();
      test_match();
      test_single_mismatch();
      test_stuck_zero();
      test_abort();
      test_async_reset();
      test_dut_in_sequence();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
